// File: rtl/alu_interface.sv
// Byte-serial front end for a combinational ALU: collects A, B and opcode from a
// UART receiver, then hands the ALU result to the UART transmitter.
module alu_interface #(
  parameter int BUS_LEN    = 8,
  parameter int OPCODE_LEN = 6,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BUS_LEN-1:0]    rx_data,
  input  logic                  rx_done,
  input  logic [BUS_LEN-1:0]    alu_result,
  input  logic                  tx_done,
  output logic [BUS_LEN-1:0]    A,
  output logic [BUS_LEN-1:0]    B,
  output logic [OPCODE_LEN-1:0] opcode,
  output logic [BUS_LEN-1:0]    tx_data,
  output logic                  tx_start,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    SEND,
    WAIT_TX
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [BUS_LEN-1:0]      a_reg, b_reg, tx_data_reg;
  logic [OPCODE_LEN-1:0]   opcode_reg;
  logic                    tx_start_reg, tx_start_next;
  logic                    run_reg;
  logic                    load_a, load_b, load_op, load_tx;

  // Reset is asserted asynchronously but released through this flop, so the
  // FSM cannot move before the second rising edge after rst_n goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= WAIT_A;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Counter restarts whenever a byte arrives or the state changes, so it
  // measures idle time between bytes of one frame.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = '0;
    load_a        = 1'b0;
    load_b        = 1'b0;
    load_op       = 1'b0;
    load_tx       = 1'b0;
    tx_start_next = 1'b0;
    if (run_reg) begin
      case (state_reg)
        WAIT_A: begin
          if (rx_done) begin
            load_a     = 1'b1;
            state_next = WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_done) begin
            load_b     = 1'b1;
            state_next = WAIT_OP;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = WAIT_A;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        WAIT_OP: begin
          if (rx_done) begin
            load_op    = 1'b1;
            state_next = SEND;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = WAIT_A;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        SEND: begin
          load_tx       = 1'b1;
          tx_start_next = 1'b1;
          state_next    = WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done) begin
            state_next = WAIT_A;
          end
        end
        default: begin
          state_next = WAIT_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      opcode_reg   <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
    end else begin
      if (load_a) begin
        a_reg <= rx_data;
      end
      if (load_b) begin
        b_reg <= rx_data;
      end
      if (load_op) begin
        opcode_reg <= rx_data[OPCODE_LEN-1:0];
      end
      // SEND follows the opcode load by one edge, so the ALU output is settled.
      if (load_tx) begin
        tx_data_reg <= alu_result;
      end
      tx_start_reg <= tx_start_next;
    end
  end

  assign A        = a_reg;
  assign B        = b_reg;
  assign opcode   = opcode_reg;
  assign tx_data  = tx_data_reg;
  assign tx_start = tx_start_reg;
  assign busy     = (state_reg == SEND) || (state_reg == WAIT_TX);

endmodule
